// File: rtl/char_feeder.sv
// Character FIFO feeding the identifier recogniser, one character per clock.
// Drives IDLE_CHAR with char_valid low whenever nothing is released.
module char_feeder #(
    parameter int          DEPTH     = 8,
    parameter logic [7:0]  IDLE_CHAR = 8'h00
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_char,
    input  logic                       hold,
    input  logic                       clr_ovf,
    output logic [7:0]                 char,
    output logic                       char_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_FULL
    } state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    char_q, char_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic          pop, wr_acc, wr_drop;
    state_t        state;

    // Occupancy view is purely a decode of the level counter.
    always_comb begin
        state = S_PARTIAL;
        if (level_q == '0)
            state = S_EMPTY;
        else if (level_q == LW'(DEPTH))
            state = S_FULL;
    end

    assign empty = (state == S_EMPTY);
    assign full  = (state == S_FULL);

    assign pop     = !hold && !empty;
    assign wr_acc  = wr_en && (!full || pop);
    assign wr_drop = wr_en && full && !pop;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        char_d   = IDLE_CHAR;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        if (pop) begin
            char_d   = mem_q[rd_ptr_q];
            valid_d  = 1'b1;
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_acc)
            wr_ptr_d = wr_ptr_q + AW'(1);
        if (wr_acc && !pop)
            level_d = level_q + LW'(1);
        else if (pop && !wr_acc)
            level_d = level_q - LW'(1);
        // A drop in the same cycle as a clear must remain visible.
        if (wr_drop)
            ovf_d = 1'b1;
        else if (clr_ovf)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            char_q   <= IDLE_CHAR;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            char_q   <= char_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem_q[wr_ptr_q] <= wr_char;
    end

    assign char       = char_q;
    assign char_valid = valid_q;
    assign level      = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_char_feeder.sv
// Directed bench for char_feeder with a scoreboard of accepted characters.
module tb_char_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_char;
    logic       hold;
    logic       clr_ovf;
    logic [7:0] char;
    logic       char_valid;
    logic       full;
    logic       empty;
    logic [3:0] level;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int mlev   = 0;
    bit movf   = 1'b0;
    logic [7:0] exp_q [$];

    char_feeder #(.DEPTH(8), .IDLE_CHAR(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_char    (wr_char),
        .hold       (hold),
        .clr_ovf    (clr_ovf),
        .char       (char),
        .char_valid (char_valid),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit pe, acc, drp, clr;
        logic [7:0] wc, e;
        pe  = !hold && (mlev > 0);
        acc = wr_en && ((mlev < 8) || pe);
        drp = wr_en && (mlev == 8) && !pe;
        clr = clr_ovf;
        wc  = wr_char;
        @(posedge clk);
        #1;
        chk("char_valid", 32'(char_valid), 32'(pe));
        if (pe) begin
            e = exp_q.pop_front();
            chk("char", 32'(char), 32'(e));
        end else begin
            chk("idle_char", 32'(char), 32'h00);
        end
        if (acc)
            exp_q.push_back(wc);
        mlev = mlev + int'(acc) - int'(pe);
        if (drp)
            movf = 1'b1;
        else if (clr)
            movf = 1'b0;
        chk("level", 32'(level), 32'(mlev));
        chk("full", 32'(full), 32'(mlev == 8));
        chk("empty", 32'(empty), 32'(mlev == 0));
        chk("overflow", 32'(overflow), 32'(movf));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_char", 32'(char), 32'h00);
        chk("rst_valid", 32'(char_valid), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_char = 8'h00;
        hold    = 1'b0;
        clr_ovf = 1'b0;
        #2;
        chk_reset_outputs();
        #10 rst_n = 1'b1;
        repeat (2) step();

        // basic stream
        wr_en = 1'b1;
        wr_char = 8'h61; step();
        wr_char = 8'h31; step();
        wr_char = 8'h62; step();
        wr_en = 1'b0;
        step();
        chk("basic_last", 32'(char), 32'h62);
        step();

        // fill and overflow while held
        hold = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wr_char = 8'h41 + 8'(i);
            step();
            if (i == 7)
                chk("full_after_8", 32'(full), 32'h1);
        end
        chk("ovf_after_9", 32'(overflow), 32'h1);
        wr_en = 1'b0;
        hold = 1'b0;
        repeat (9) step();
        chk("drained_no_49", 32'(exp_q.size()), 32'h0);

        clr_ovf = 1'b1; step();
        clr_ovf = 1'b0;

        // full with simultaneous pop and write
        hold = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_char = 8'h70 + 8'(i);
            step();
        end
        hold = 1'b0;
        wr_char = 8'h5A;
        step();
        chk("full_pw_level", 32'(level), 32'h8);
        wr_en = 1'b0;
        repeat (8) step();
        chk("full_pw_last", 32'(char), 32'h5A);
        step();

        // overflow priority
        hold = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_char = 8'h20 + 8'(i);
            step();
        end
        wr_char = 8'hEE;
        clr_ovf = 1'b1;
        step();
        chk("ovf_set_wins", 32'(overflow), 32'h1);
        wr_en = 1'b0;
        step();
        chk("ovf_cleared", 32'(overflow), 32'h0);
        clr_ovf = 1'b0;
        hold = 1'b0;
        repeat (9) step();

        // wrap-around stream, includes a stored 8'h00
        wr_en = 1'b1;
        for (int i = 0; i < 27; i++) begin
            wr_char = 8'(i * 7);
            step();
        end
        wr_en = 1'b0;
        repeat (2) step();

        // reset mid-stream with 3 entries buffered
        hold = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_char = 8'h90 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        hold = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        mlev = 0;
        movf = 1'b0;
        exp_q.delete();
        #2 rst_n = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/char_feeder.md
# char_feeder

Byte-stream feeder that sits directly upstream of the identifier recogniser and drives its `char` input. It buffers characters written by a producer in a small FIFO and releases at most one per clock. When it has nothing to send, or is held, it drives an idle character. The identifier recogniser ignores characters that are neither letters nor digits, so the idle character leaves its state unchanged.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `IDLE_CHAR`, 8'h00: value driven on `char` when no character is released; must be neither a letter nor a digit.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  producer write strobe, one character per cycle.
- `wr_char`  in  8  character to write, sampled when `wr_en`=1.
- `hold`  in  1  1 = do not release a character this cycle.
- `clr_ovf`  in  1  clears `overflow`.
- `char`  out  8  registered character to the identifier recogniser.
- `char_valid`  out  1  registered; 1 = `char` is a released FIFO entry, 0 = `char` is `IDLE_CHAR`.
- `full`  out  1  level == DEPTH.
- `empty`  out  1  level == 0.
- `level`  out  $clog2(DEPTH)+1  number of stored entries.
- `overflow`  out  1  sticky flag; set when a write is dropped.

## Operation
- **Storage:** circular buffer of DEPTH×8 bits.
  - Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH with no special case.
  - `level` is a separate counter, not a pointer difference.
- **Pop condition:** pop = !hold && !empty. Decided on the pre-edge state.
- **On pop:** `char` ← head entry, `char_valid` ← 1, read pointer +1.
- **No pop:** `char` ← IDLE_CHAR, `char_valid` ← 0.
  - `char` never holds a stale entry for more than one cycle.
- **Write accepted** when wr_en && (!full || pop).
  - Writing into a full FIFO is accepted if a pop occurs in the same cycle.
  - Accepted write: entry at write pointer ← `wr_char`, write pointer +1.
- **Write dropped** when wr_en && full && !pop.
  - Storage and pointers unchanged; `overflow` ← 1.
- **Level update:** +1 on write only, −1 on pop only, unchanged on both or neither.
- **Overflow flag:** `clr_ovf` clears it. If a drop and `clr_ovf` happen in the same cycle, set wins (`overflow`=1).
- **No bypass:** a write into an empty FIFO is not forwarded combinationally; it is popped at the next eligible edge.
- **No character filtering:** all 256 values are stored and released unchanged, including IDLE_CHAR itself. The consumer distinguishes a stored IDLE_CHAR from idle only by `char_valid`.
- **FSM view:** EMPTY / PARTIAL / FULL, derived from `level`, with no extra state register.
  - EMPTY→PARTIAL on write without pop.
  - PARTIAL→FULL when level reaches DEPTH.
  - FULL→PARTIAL on pop without write.
  - PARTIAL→EMPTY when the last entry is popped with no write.

## Timing
- **Reset values (rst_n=0, immediate, asynchronous):** `char`=IDLE_CHAR, `char_valid`=0, `level`=0, `empty`=1, `full`=0, `overflow`=0, both pointers 0. Storage contents are don't-care.
- **Reset mid-stream:** all buffered characters are discarded. The first edge after deassertion behaves as empty.
- **Latency:** a character accepted at edge k into an empty FIFO with `hold`=0 appears on `char` after edge k+1.
- **Throughput:** one character per cycle sustained; write and pop in the same cycle every cycle keeps `level` constant.
- **Flag timing:** `full`, `empty` and `level` reflect state after the most recent edge; `full` and `empty` are combinational from `level`.
- **Hold:** asserted at edge k, forces `char_valid`=0 and `char`=IDLE_CHAR after edge k. Writes continue while held.
- **Ordering:** strict FIFO; output order equals accepted-write order across any number of pointer wraps.

## Test plan
- **Reset:** drive rst_n=0 mid-cycle with 3 entries stored → outputs at reset values immediately. After release with no writes, `char`=8'h00 and `char_valid`=0 on every edge.
- **Basic stream:** write "a","1","b" on 3 consecutive edges with hold=0 → `char` = 8'h61, 8'h31, 8'h62 after edges 2–4, each with `char_valid`=1. After edge 5, `char`=8'h00 and `char_valid`=0.
- **Fill and overflow:** hold=1, write 9 characters 8'h41..8'h49 → `level`=8 and `full`=1 after the 8th write. The 9th write (8'h49) is dropped and `overflow`=1. Release hold → 8'h41..8'h48 emerge in order, with no 8'h49.
- **Full with simultaneous pop and write:** level=8, hold=0, write 8'h5A → write accepted and `level` stays 8. 8'h5A emerges as the 8th character after the current head.
- **Wrap-around:** continuous write and pop for 3×DEPTH+3 cycles with an incrementing pattern → output equals input delayed by 1 cycle, and `level` stays constant.
- **Overflow priority:** assert a dropped write and `clr_ovf` in the same cycle → `overflow`=1. `clr_ovf` alone on the next cycle → `overflow`=0.
